key_event_gen: RTL and testbench
================================

Name: key_event_gen

Overview:
- Consumer side of the push-button debouncer.
- Takes the debounced key level, which comes from the 1 ms-clocked debounce domain and is asynchronous to clk.
- Turns that level into single-cycle game events in the clk domain: press, release, long-press, and auto-repeat while held.
- Also reports how long the key has been held, in milliseconds.
- One instance per game key; the outputs feed the note-hit judge and the menu navigation logic.

Parameters:
- CLK_PER_MS, 100000: clk cycles per millisecond tick (100 MHz clk).
- LONG_MS, 500: hold duration in ms that triggers long_press.
- REPEAT_MS, 100: period of repeat_evt in ms once in long-press.
- CNT_W, 10: width of hold_ms and of the internal ms counters.

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- level_in, input, 1: debounced key level; 1 = pressed; asynchronous to clk.
- en, input, 1: event enable; 0 forces idle and suppresses all events.
- press, output, 1: one-cycle pulse on key press.
- release, output, 1: one-cycle pulse on key release.
- long_press, output, 1: one-cycle pulse when the hold reaches LONG_MS.
- repeat_evt, output, 1: one-cycle pulse every REPEAT_MS while in long-press.
- held, output, 1: 1 while the FSM is in PRESSED or LONG.
- hold_ms, output, CNT_W: ms elapsed since the last press, saturating.

Behaviour:
- Reset values:
  - Synchronizer flops sync1, sync2 and edge flop prev all reset to 1.
  - FSM resets to IDLE. Prescaler, repeat counter and hold_ms reset to 0.
  - All pulse outputs and held reset to 0.
  - Consequence: a key held through reset produces no press. A key up at reset yields a fall in IDLE, which is ignored.
- Synchronizer and edge detect:
  - level_in -> sync1 -> sync2 -> prev.
  - rise = sync2 & ~prev; fall = ~sync2 & prev.
- Latency: press or release is asserted for exactly one cycle, starting at the 3rd rising clk edge after a level_in transition that meets setup.
- Prescaler:
  - Counts 0..CLK_PER_MS-1 while held.
  - tick = 1 for one cycle when the count is CLK_PER_MS-1; the count then wraps to 0.
  - Cleared to 0 on every accepted press, so the first tick occurs CLK_PER_MS cycles after press.
  - Held at 0 in IDLE.
- FSM states: IDLE, PRESSED, LONG.
  - IDLE, rise & en -> PRESSED. press=1; hold_ms<=0; prescaler<=0.
  - PRESSED, fall -> IDLE. release=1.
  - PRESSED, tick and hold_ms+1 == LONG_MS -> LONG. long_press=1; repeat counter<=0.
  - LONG, tick -> repeat counter +1. When it reaches REPEAT_MS: repeat_evt=1, counter<=0. First repeat_evt is REPEAT_MS ticks after long_press.
  - LONG, fall -> IDLE. release=1.
  - Any state, en=0 -> IDLE in the next cycle, with no release pulse. A rise while en=0 is lost; the key must be released and pressed again.
- hold_ms:
  - Increments on tick while held.
  - Saturates at 2^CNT_W-1; never wraps.
  - Retains its value in IDLE until the next press.
- Simultaneous events and priority:
  - A fall in the same cycle as the tick that would trigger long_press: release wins. Go to IDLE; no long_press.
  - A fall coinciding with a repeat tick: release only.
  - Priority order: en=0 > fall > tick.
- Parameter constraints:
  - LONG_MS >= 1 and REPEAT_MS >= 1.
  - LONG_MS < 2^CNT_W, so the saturating count can reach it.
- Exclusivity: at most one of press, release, long_press, repeat_evt is high in any cycle.
- held goes to 1 in the same cycle as press and to 0 in the same cycle as release.

Test Plan:
Bench parameters: CLK_PER_MS=4, LONG_MS=3, REPEAT_MS=2, CNT_W=4.
- Short tap: level_in 0->1 for 10 cycles, then 0, en=1.
  - press at edge 3 after the rise.
  - hold_ms reaches 2.
  - release 3 edges after the fall.
  - No long_press. hold_ms stays at 2 afterwards.
- Long hold: level_in=1 for 40 cycles.
  - long_press 12 cycles after press.
  - repeat_evt 8 and 16 cycles after long_press.
  - Exactly one release; held is high throughout.
- Tie case: level_in falls so that fall lands in the same cycle as the 3rd tick.
  - release only; no long_press; FSM returns to IDLE.
- Reset with key held: rst_n low with level_in=1, then rst_n high for 20 cycles.
  - No press, no release. A later 1->0->1 on level_in produces one press.
- Enable drop: en 1->0 while in LONG.
  - No further pulses; held drops 1 cycle later; no release.
  - en->1 with the key still down: no press.
- Saturation: hold for 20 ms with CNT_W=4.
  - hold_ms stops at 15 and does not wrap; repeat_evt keeps firing every 8 cycles.

Source files
------------

// File: rtl/key_event_gen_if.sv
// Key event bundle: the debounced key level and enable go into the event
// generator, and the single-cycle game events plus the hold time come back out.
// The release event is named release_evt because `release` is a reserved word.
interface key_event_gen_if #(
  parameter int CNT_W = 10
);
  logic             level_in;
  logic             en;
  logic             press;
  logic             release_evt;
  logic             long_press;
  logic             repeat_evt;
  logic             held;
  logic [CNT_W-1:0] hold_ms;

  // Consumer side: drives the key level and enable, and receives the events.
  modport master (
    output level_in, en,
    input  press, release_evt, long_press, repeat_evt, held, hold_ms
  );

  // Event generator side.
  modport slave (
    input  level_in, en,
    output press, release_evt, long_press, repeat_evt, held, hold_ms
  );
endinterface

// File: rtl/key_event_gen.sv
// Key event generator: turns the asynchronous debounced key level into
// single-cycle press / release / long-press / auto-repeat events in the clk
// domain, and reports the hold time in milliseconds (saturating).
module key_event_gen #(
  parameter int CLK_PER_MS = 100000,
  parameter int LONG_MS    = 500,
  parameter int REPEAT_MS  = 100,
  parameter int CNT_W      = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  key_event_gen_if.slave     bus
);

  localparam int PS_W  = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam int RPT_W = (REPEAT_MS > 1) ? $clog2(REPEAT_MS) : 1;

  localparam logic [PS_W-1:0]  PS_LAST   = PS_W'(CLK_PER_MS - 1);
  localparam logic [RPT_W-1:0] RPT_LAST  = RPT_W'(REPEAT_MS - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_MS - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } state_t;

  state_t           state;
  logic             sync1, sync2, prev;
  logic [PS_W-1:0]  presc;
  logic [RPT_W-1:0] rpt;
  logic [CNT_W-1:0] hold_ms;
  logic             press, release_evt, long_press, repeat_evt, held;

  logic rise, fall, tick;

  // Two-flop synchronizer for the async key level, plus the edge-detect flop.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its source; blocking here would collapse the chain.
  // The chain resets to 1 so a key held through reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= bus.level_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rise = sync2 & ~prev;
  assign fall = ~sync2 & prev;
  assign tick = (state != IDLE) && (presc == PS_LAST);

  // Event FSM with prescaler, repeat counter and hold timer; all outputs
  // registered. Priority: en=0, then fall, then tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      presc       <= '0;
      rpt         <= '0;
      hold_ms     <= '0;
      press       <= 1'b0;
      release_evt <= 1'b0;
      long_press  <= 1'b0;
      repeat_evt  <= 1'b0;
      held        <= 1'b0;
    end else begin
      press       <= 1'b0;
      release_evt <= 1'b0;
      long_press  <= 1'b0;
      repeat_evt  <= 1'b0;

      if (!bus.en) begin
        // Forced idle: no release pulse, and any rise seen now is lost.
        state <= IDLE;
        held  <= 1'b0;
        presc <= '0;
      end else begin
        case (state)
          IDLE: begin
            presc <= '0;
            if (rise) begin
              state   <= PRESSED;
              press   <= 1'b1;
              held    <= 1'b1;
              hold_ms <= '0;
            end
          end

          PRESSED: begin
            if (fall) begin
              state       <= IDLE;
              release_evt <= 1'b1;
              held        <= 1'b0;
              presc       <= '0;
            end else if (tick) begin
              presc <= '0;
              if (hold_ms != HOLD_MAX) hold_ms <= hold_ms + CNT_W'(1);
              if (hold_ms == LONG_LAST) begin
                state      <= LONG;
                long_press <= 1'b1;
                rpt        <= '0;
              end
            end else begin
              presc <= presc + PS_W'(1);
            end
          end

          LONG: begin
            if (fall) begin
              state       <= IDLE;
              release_evt <= 1'b1;
              held        <= 1'b0;
              presc       <= '0;
            end else if (tick) begin
              presc <= '0;
              if (hold_ms != HOLD_MAX) hold_ms <= hold_ms + CNT_W'(1);
              if (rpt == RPT_LAST) begin
                repeat_evt <= 1'b1;
                rpt        <= '0;
              end else begin
                rpt <= rpt + RPT_W'(1);
              end
            end else begin
              presc <= presc + PS_W'(1);
            end
          end

          default: begin
            state <= IDLE;
            held  <= 1'b0;
            presc <= '0;
          end
        endcase
      end
    end
  end

  assign bus.press       = press;
  assign bus.release_evt = release_evt;
  assign bus.long_press  = long_press;
  assign bus.repeat_evt  = repeat_evt;
  assign bus.held        = held;
  assign bus.hold_ms     = hold_ms;

endmodule

// File: tb/tb_key_event_gen.sv
// Directed testbench for key_event_gen with CLK_PER_MS=4, LONG_MS=3,
// REPEAT_MS=2, CNT_W=4. Cycle index c counts rising edges after the stimulus
// change; outputs are sampled 1 time unit after each rising edge.
module tb_key_event_gen;

  localparam int CLK_PER_MS = 4;
  localparam int LONG_MS    = 3;
  localparam int REPEAT_MS  = 2;
  localparam int CNT_W      = 4;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  key_event_gen_if #(.CNT_W(CNT_W)) bus ();

  key_event_gen #(
    .CLK_PER_MS (CLK_PER_MS),
    .LONG_MS    (LONG_MS),
    .REPEAT_MS  (REPEAT_MS),
    .CNT_W      (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    int n_pulse = 0;
    bus.level_in = 1'b0;
    bus.en       = 1'b1;
    rst_n        = 1'b0;
    idle_cycles(2);
    checks++;
    if ({bus.press, bus.release_evt, bus.long_press, bus.repeat_evt, bus.held} !== 5'b0) begin
      failures++;
      $display("FAIL reset_pulses: got %b expected 00000",
               {bus.press, bus.release_evt, bus.long_press, bus.repeat_evt, bus.held});
    end
    checks++;
    if (bus.hold_ms !== 4'd0) begin
      failures++;
      $display("FAIL reset_hold_ms: got %0d expected 0", bus.hold_ms);
    end
    rst_n = 1'b1;
    // Key up at reset produces a fall in IDLE that must be ignored.
    for (int c = 1; c <= 10; c++) begin
      step();
      if (bus.press || bus.release_evt || bus.long_press || bus.repeat_evt) n_pulse++;
    end
    checks++;
    if (n_pulse !== 0) begin
      failures++;
      $display("FAIL reset_fall_ignored: got %0d pulses expected 0", n_pulse);
    end
  endtask

  task automatic test_short_tap();
    int n_press = 0, n_rel = 0, n_long = 0, at_press = -1, at_rel = -1;
    bus.level_in = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (bus.press)       begin n_press++; at_press = c; end
      if (bus.release_evt) begin n_rel++;   at_rel   = c; end
      if (bus.long_press)  n_long++;
      if (c == 3) begin
        checks++;
        if (bus.held !== 1'b1) begin
          failures++;
          $display("FAIL tap_held_with_press: got %b expected 1", bus.held);
        end
      end
      if (c == 13) begin
        checks++;
        if (bus.held !== 1'b0) begin
          failures++;
          $display("FAIL tap_held_with_release: got %b expected 0", bus.held);
        end
      end
      if (c == 10) bus.level_in = 1'b0;
    end
    checks++;
    if (n_press !== 1 || at_press !== 3) begin
      failures++;
      $display("FAIL tap_press: got count %0d at %0d expected count 1 at 3", n_press, at_press);
    end
    checks++;
    if (n_rel !== 1 || at_rel !== 13) begin
      failures++;
      $display("FAIL tap_release: got count %0d at %0d expected count 1 at 13", n_rel, at_rel);
    end
    checks++;
    if (n_long !== 0) begin
      failures++;
      $display("FAIL tap_no_long: got %0d expected 0", n_long);
    end
    checks++;
    if (bus.hold_ms !== 4'd2) begin
      failures++;
      $display("FAIL tap_hold_ms_retained: got %0d expected 2", bus.hold_ms);
    end
  endtask

  task automatic test_long_hold();
    int n_rel = 0, n_long = 0, n_rpt = 0, at_long = -1, at_rel = -1;
    int rpt_at[3] = '{-1, -1, -1};
    int held_low = 0;
    bus.level_in = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      step();
      if (bus.long_press)  begin n_long++; at_long = c; end
      if (bus.release_evt) begin n_rel++;  at_rel  = c; end
      if (bus.repeat_evt) begin
        if (n_rpt < 3) rpt_at[n_rpt] = c;
        n_rpt++;
      end
      if (c >= 3 && c <= 42 && bus.held !== 1'b1) held_low++;
      if (c == 40) begin
        checks++;
        if (bus.hold_ms !== 4'd9) begin
          failures++;
          $display("FAIL long_hold_ms: got %0d expected 9", bus.hold_ms);
        end
        bus.level_in = 1'b0;
      end
    end
    checks++;
    if (n_long !== 1 || at_long !== 15) begin
      failures++;
      $display("FAIL long_press: got count %0d at %0d expected count 1 at 15", n_long, at_long);
    end
    checks++;
    if (n_rpt !== 3 || rpt_at[0] !== 23 || rpt_at[1] !== 31 || rpt_at[2] !== 39) begin
      failures++;
      $display("FAIL long_repeat: got count %0d at %0d,%0d,%0d expected count 3 at 23,31,39",
               n_rpt, rpt_at[0], rpt_at[1], rpt_at[2]);
    end
    checks++;
    if (n_rel !== 1 || at_rel !== 43) begin
      failures++;
      $display("FAIL long_release: got count %0d at %0d expected count 1 at 43", n_rel, at_rel);
    end
    checks++;
    if (held_low !== 0) begin
      failures++;
      $display("FAIL long_held: got %0d low cycles expected 0", held_low);
    end
  endtask

  task automatic test_tie();
    int n_rel = 0, n_long = 0, n_rpt = 0, at_rel = -1;
    bus.level_in = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      step();
      if (bus.release_evt) begin n_rel++; at_rel = c; end
      if (bus.long_press)  n_long++;
      if (bus.repeat_evt)  n_rpt++;
      if (c == 12) bus.level_in = 1'b0;
    end
    checks++;
    if (n_rel !== 1 || at_rel !== 15) begin
      failures++;
      $display("FAIL tie_release: got count %0d at %0d expected count 1 at 15", n_rel, at_rel);
    end
    checks++;
    if (n_long !== 0 || n_rpt !== 0) begin
      failures++;
      $display("FAIL tie_no_long: got long %0d repeat %0d expected 0 0", n_long, n_rpt);
    end
    checks++;
    if (bus.held !== 1'b0) begin
      failures++;
      $display("FAIL tie_idle: got held %b expected 0", bus.held);
    end
  endtask

  task automatic test_reset_held();
    int n_press = 0, n_rel = 0, at_press = -1;
    bus.level_in = 1'b1;
    rst_n        = 1'b0;
    idle_cycles(2);
    rst_n = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (bus.press)       n_press++;
      if (bus.release_evt) n_rel++;
    end
    checks++;
    if (n_press !== 0 || n_rel !== 0 || bus.held !== 1'b0) begin
      failures++;
      $display("FAIL reset_held_quiet: got press %0d release %0d held %b expected 0 0 0",
               n_press, n_rel, bus.held);
    end
    bus.level_in = 1'b0;
    idle_cycles(5);
    bus.level_in = 1'b1;
    n_press = 0;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (bus.press) begin n_press++; at_press = c; end
    end
    checks++;
    if (n_press !== 1 || at_press !== 3) begin
      failures++;
      $display("FAIL reset_held_repress: got count %0d at %0d expected count 1 at 3", n_press, at_press);
    end
    bus.level_in = 1'b0;
    n_rel = 0;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (bus.release_evt) n_rel++;
    end
    checks++;
    if (n_rel !== 1) begin
      failures++;
      $display("FAIL reset_held_release: got %0d expected 1", n_rel);
    end
  endtask

  task automatic test_enable_drop();
    int n_long = 0, at_long = -1, n_after = 0;
    bus.level_in = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      step();
      if (bus.long_press) begin n_long++; at_long = c; end
      if (c >= 18 && (bus.press || bus.release_evt || bus.long_press || bus.repeat_evt)) n_after++;
      if (c == 17) begin
        checks++;
        if (bus.held !== 1'b1) begin
          failures++;
          $display("FAIL en_held_before: got %b expected 1", bus.held);
        end
        bus.en = 1'b0;
      end
      if (c == 18) begin
        checks++;
        if (bus.held !== 1'b0) begin
          failures++;
          $display("FAIL en_held_drop: got %b expected 0", bus.held);
        end
      end
      if (c == 25) bus.en = 1'b1;
      if (c == 40) bus.level_in = 1'b0;
    end
    checks++;
    if (n_long !== 1 || at_long !== 15) begin
      failures++;
      $display("FAIL en_long_press: got count %0d at %0d expected count 1 at 15", n_long, at_long);
    end
    checks++;
    if (n_after !== 0) begin
      failures++;
      $display("FAIL en_no_pulses: got %0d pulses expected 0", n_after);
    end
  endtask

  task automatic test_saturation();
    int exp_hold;
    logic exp_rpt;
    bus.level_in = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      step();
      if (c >= 3) begin
        exp_hold = (c < 7) ? 0 : (((c - 7) / 4 + 1 > 15) ? 15 : (c - 7) / 4 + 1);
        checks++;
        if (bus.hold_ms !== CNT_W'(exp_hold)) begin
          failures++;
          $display("FAIL sat_hold_ms c=%0d: got %0d expected %0d", c, bus.hold_ms, exp_hold);
        end
        exp_rpt = (c >= 23) && ((c - 23) % 8 == 0);
        checks++;
        if (bus.repeat_evt !== exp_rpt) begin
          failures++;
          $display("FAIL sat_repeat c=%0d: got %b expected %b", c, bus.repeat_evt, exp_rpt);
        end
      end
    end
    bus.level_in = 1'b0;
    idle_cycles(10);
    checks++;
    if (bus.held !== 1'b0 || bus.hold_ms !== 4'd15) begin
      failures++;
      $display("FAIL sat_after_release: got held %b hold_ms %0d expected 0 15", bus.held, bus.hold_ms);
    end
  endtask

  initial begin
    test_reset();
    test_short_tap();
    test_long_hold();
    test_tie();
    test_reset_held();
    test_enable_drop();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
